exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage LoongArch pipeline, directly downstream of the decode stage and upstream of the memory stage.
- Latches the decode bundle and evaluates ALU ops 0–11 and the single-cycle multiplies.
- Runs an iterative 32-step divider for div/mod, issuing the data-SRAM request for loads and stores.
- Drives the forwarding/stall bundle consumed by decode.

Parameters:
ID2EXE_LEN, 174, width of the decode bundle.
EXE2MEM_LEN, 91, width of the memory-stage bundle.

Ports:
clk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
flush  in  1  exception/ertn flush from WB.
mem_wb_ex  in  1  exception or ertn currently valid in MEM or WB; kills store issue.
exe_allowin  out  1  decode may hand over this cycle.
id_to_exe_valid  in  1  decode bundle valid.
id_to_exe_zip  in  174  {alu_op[18:0], res_from_mem, src1[31:0], src2[31:0], mem_op[3:0], rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0], ex_valid, ecode[5:0], esubcode[7:0], is_ertn}.
mem_allowin  in  1  memory stage can accept.
exe_to_mem_valid  out  1  bundle valid to MEM.
exe_to_mem_zip  out  91  {res_from_mem, mem_op[3:0], rf_we, rf_waddr[4:0], result[31:0], pc[31:0], ex_valid, ecode[5:0], esubcode[7:0], is_ertn}.
exe_rf_zip  out  39  {not_ready, rf_we, rf_waddr[4:0], result[31:0]} for decode forwarding.
data_sram_en  out  1  data SRAM request.
data_sram_we  out  4  byte write enables.
data_sram_addr  out  32  byte address (the result).
data_sram_wdata  out  32  lane-replicated store data.

Behaviour:
- Reset (async, resetn=0): exe_valid=0, divider state IDLE, counter=0. All outputs gated by exe_valid, so they reset to 0 except exe_allowin=1.
- Handshake:
  - exe_allowin = ~exe_valid | (ready_go & mem_allowin).
  - exe_to_mem_valid = exe_valid & ready_go.
  - The bundle is latched when id_to_exe_valid & exe_allowin.
  - exe_valid loads id_to_exe_valid when exe_allowin.
- flush has priority over all other events: it clears exe_valid and forces the divider to IDLE on the same edge. It overrides a simultaneous accept.
- ALU (ops 0–11): add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui(=src2).
  - Shift amount is src2[4:0].
  - ready_go=1 in the first cycle.
- Multiply (ops 12–14): 64-bit product, same cycle.
  - mul.w returns the low 32 bits.
  - mulh.w returns the high 32 bits of the signed product; mulh.wu the high 32 bits of the unsigned product.
- Divide (ops 15–18), FSM IDLE→BUSY→DONE:
  - IDLE: when exe_valid and a div op is present, load the operand magnitudes (|src1|, |src2| for signed ops) and go to BUSY with counter=0.
  - BUSY: one restoring step per cycle. Counter increments; after step 31 go to DONE.
  - DONE: ready_go=1. Return to IDLE on the exe_to_mem handshake.
  - Latency: the first EXE cycle is IDLE, then 32 BUSY cycles, then DONE. The result is valid in the 34th EXE cycle.
  - Sign fix: quotient is negated if the operand signs differ; remainder takes the sign of src1.
  - Divide by zero (any of the four ops): q=0xFFFFFFFF, r=src1.
  - 0x80000000 / 0xFFFFFFFF (signed): q=0x80000000, r=0.
- not_ready = exe_valid & (res_from_mem | (div op & ~DONE)). Decode treats it as a load-use stall, so a div result is never forwarded early.
- exe_rf_zip.rf_we = exe_valid & rf_we.
- Memory request:
  - store = mem_op[2].
  - Size from mem_op[1:0]: 00 byte, 01 half, 10 word.
  - data_sram_en = exe_valid & ready_go & mem_allowin & (res_from_mem | store) & ~kill, where kill = flush | mem_wb_ex | ex_valid | is_ertn.
  - Store data: byte is replicated ×4, half ×2.
  - Byte enables: byte gives 1<<addr[1:0]; half gives 0011 or 1100 by addr[1]; word gives 1111.
  - Loads use we=0000.
  - Alignment is not checked.
- Bundle fields not computed here pass straight through to MEM.

Test Plan:
- add.w src1=5, src2=0xFFFFFFFE -> result 3 the cycle after accept, exe_to_mem_valid=1 with mem_allowin=1.
- mulh.w 0x80000000×2 -> 0xFFFFFFFF; mulh.wu same operands -> 0x00000001; mul.w -> 0.
- div.w −7/2 -> q=0xFFFFFFFD in the 34th EXE cycle; mod.w -> r=0xFFFFFFFF. Check not_ready=1 for cycles 1–33 and exe_allowin=0 throughout.
- div.wu 10/0 -> q=0xFFFFFFFF; mod.wu 10/0 -> r=10. Also 0x80000000 div.w 0xFFFFFFFF -> 0x80000000.
- st.b addr=0x1003, rkd=0x12345678 -> we=1000, wdata=0x78787878. The same store with mem_wb_ex=1 -> data_sram_en=0.
- flush at BUSY counter=10 -> exe_valid=0 next edge, FSM IDLE, exe_allowin=1. A new add accepted afterwards completes in 1 cycle.

Source files
------------

// File: rtl/exe_stage_if.sv
// Decode->execute->memory handshake, forwarding and data-SRAM request signals of the
// execute stage. The master modport is the execute stage; the slave modport is its surroundings.
interface exe_stage_if #(
  parameter int unsigned ID2EXE_LEN  = 174,
  parameter int unsigned EXE2MEM_LEN = 91
);
  logic                   exe_allowin;
  logic                   id_to_exe_valid;
  logic [ID2EXE_LEN-1:0]  id_to_exe_zip;
  logic                   mem_allowin;
  logic                   exe_to_mem_valid;
  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip;
  logic [38:0]            exe_rf_zip;
  logic                   data_sram_en;
  logic [3:0]             data_sram_we;
  logic [31:0]            data_sram_addr;
  logic [31:0]            data_sram_wdata;

  modport master (
    input  id_to_exe_valid, id_to_exe_zip, mem_allowin,
    output exe_allowin, exe_to_mem_valid, exe_to_mem_zip, exe_rf_zip,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output id_to_exe_valid, id_to_exe_zip, mem_allowin,
    input  exe_allowin, exe_to_mem_valid, exe_to_mem_zip, exe_rf_zip,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle multiply, 32-step restoring divider and data-SRAM request.
// alu_op is one-hot: 0-11 ALU, 12 mul.w, 13 mulh.w, 14 mulh.wu, 15 div.w, 16 mod.w, 17 div.wu, 18 mod.wu.
module exe_stage #(
  parameter int unsigned ID2EXE_LEN  = 174,
  parameter int unsigned EXE2MEM_LEN = 91
) (
  input logic         clk,
  input logic         resetn,
  input logic         flush,
  input logic         mem_wb_ex,
  exe_stage_if.master bus
);
  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic                  exe_valid_q;
  logic [ID2EXE_LEN-1:0] zip_q;
  div_state_e            div_state_q, div_state_d;
  logic                  div_load, div_step, div_done;
  logic [31:0]           rem_q, quo_q, dsr_q;
  logic [4:0]            cnt_q;

  logic [18:0] alu_op;
  logic        res_from_mem;
  logic [31:0] src1, src2;
  logic [3:0]  mem_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rkd_value, pc;
  logic        ex_valid;
  logic [5:0]  ecode;
  logic [7:0]  esubcode;
  logic        is_ertn;

  assign {alu_op, res_from_mem, src1, src2, mem_op, rf_we, rf_waddr, rkd_value, pc,
          ex_valid, ecode, esubcode, is_ertn} = zip_q;

  logic is_div, div_signed, ready_go, out_fire, not_ready;

  assign is_div     = |alu_op[18:15];
  assign div_signed = alu_op[15] | alu_op[16];
  assign ready_go   = ~is_div | div_done;

  assign bus.exe_allowin      = ~exe_valid_q | (ready_go & bus.mem_allowin);
  assign bus.exe_to_mem_valid = exe_valid_q & ready_go;
  assign out_fire             = bus.exe_to_mem_valid & bus.mem_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      zip_q       <= '0;
    end else begin
      if (flush) begin
        exe_valid_q <= 1'b0;
      end else if (bus.exe_allowin) begin
        exe_valid_q <= bus.id_to_exe_valid;
      end
      if (bus.id_to_exe_valid && bus.exe_allowin && !flush) begin
        zip_q <= bus.id_to_exe_zip;
      end
    end
  end

  // Divider FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_q <= StIdle;
    end else begin
      div_state_q <= div_state_d;
    end
  end

  always_comb begin
    div_state_d = div_state_q;
    if (flush) begin
      div_state_d = StIdle;
    end else begin
      case (div_state_q)
        StIdle:  if (exe_valid_q && is_div) div_state_d = StBusy;
        StBusy:  if (cnt_q == 5'd31) div_state_d = StDone;
        StDone:  if (out_fire) div_state_d = StIdle;
        default: div_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    div_load = (div_state_q == StIdle) & exe_valid_q & is_div & ~flush;
    div_step = (div_state_q == StBusy);
    div_done = (div_state_q == StDone);
  end

  // Divider datapath: unsigned restoring division on operand magnitudes.
  logic        src1_neg, src2_neg, ge;
  logic [31:0] src1_abs, src2_abs;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  assign src1_neg = div_signed & src1[31];
  assign src2_neg = div_signed & src2[31];
  assign src1_abs = src1_neg ? (32'd0 - src1) : src1;
  assign src2_abs = src2_neg ? (32'd0 - src2) : src2;
  assign rem_sh   = {rem_q, quo_q[31]};
  assign diff     = {1'b0, rem_sh} - {2'b00, dsr_q};
  assign ge       = ~diff[33];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (div_load) begin
      rem_q <= '0;
      quo_q <= src1_abs;
      dsr_q <= src2_abs;
      cnt_q <= '0;
    end else if (div_step) begin
      rem_q <= ge ? diff[31:0] : rem_sh[31:0];
      quo_q <= {quo_q[30:0], ge};
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // The magnitude algorithm already yields 0x80000000 / 0 for the signed overflow case.
  logic        div_by_zero;
  logic [31:0] quot, remd;

  assign div_by_zero = (src2 == 32'd0);
  assign quot = div_by_zero ? 32'hFFFF_FFFF :
                (src1_neg ^ src2_neg) ? (32'd0 - quo_q) : quo_q;
  assign remd = div_by_zero ? src1 : src1_neg ? (32'd0 - rem_q) : rem_q;

  logic [63:0] smul, umul;
  logic [31:0] result;

  assign smul = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign umul = {32'd0, src1} * {32'd0, src2};

  assign result = ({32{alu_op[0]}}  & (src1 + src2))
                | ({32{alu_op[1]}}  & (src1 - src2))
                | ({32{alu_op[2]}}  & {31'd0, $signed(src1) < $signed(src2)})
                | ({32{alu_op[3]}}  & {31'd0, src1 < src2})
                | ({32{alu_op[4]}}  & (src1 & src2))
                | ({32{alu_op[5]}}  & ~(src1 | src2))
                | ({32{alu_op[6]}}  & (src1 | src2))
                | ({32{alu_op[7]}}  & (src1 ^ src2))
                | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                | ({32{alu_op[10]}} & 32'($signed(src1) >>> src2[4:0]))
                | ({32{alu_op[11]}} & src2)
                | ({32{alu_op[12]}} & smul[31:0])
                | ({32{alu_op[13]}} & smul[63:32])
                | ({32{alu_op[14]}} & umul[63:32])
                | ({32{alu_op[15] | alu_op[17]}} & quot)
                | ({32{alu_op[16] | alu_op[18]}} & remd);

  // Memory request
  logic        store, kill;
  logic [3:0]  we_mask;
  logic [31:0] wdata;

  assign store = mem_op[2];
  assign kill  = flush | mem_wb_ex | ex_valid | is_ertn;

  always_comb begin
    we_mask = 4'b1111;
    wdata   = rkd_value;
    case (mem_op[1:0])
      2'b00: begin
        we_mask = 4'b0001 << result[1:0];
        wdata   = {4{rkd_value[7:0]}};
      end
      2'b01: begin
        we_mask = result[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{rkd_value[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.data_sram_en    = exe_valid_q & ready_go & bus.mem_allowin &
                               (res_from_mem | store) & ~kill;
  assign bus.data_sram_we    = (bus.data_sram_en & store) ? we_mask : 4'b0000;
  assign bus.data_sram_addr  = exe_valid_q ? result : 32'd0;
  assign bus.data_sram_wdata = exe_valid_q ? wdata : 32'd0;

  // Forwarding: an unfinished divide looks like a pending load so decode stalls.
  logic [EXE2MEM_LEN-1:0] mem_zip;

  assign not_ready = exe_valid_q & (res_from_mem | (is_div & ~div_done));
  assign mem_zip   = {res_from_mem, mem_op, rf_we, rf_waddr, result, pc,
                      ex_valid, ecode, esubcode, is_ertn};

  assign bus.exe_to_mem_zip = exe_valid_q ? mem_zip : '0;
  assign bus.exe_rf_zip     = exe_valid_q ? {not_ready, rf_we, rf_waddr, result} : 39'd0;
endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic resetn, flush, mem_wb_ex;
  int   n_total = 0;
  int   n_bad   = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .mem_wb_ex (mem_wb_ex),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [173:0] make_zip(input int op, input logic rfm,
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] mop, input logic we,
      input logic [4:0] wa, input logic [31:0] rkd, input logic [31:0] pc, input logic exv);
    logic [18:0] oh;
    oh     = '0;
    oh[op] = 1'b1;
    return {oh, rfm, a, b, mop, we, wa, rkd, pc, exv, 6'd0, 8'd0, 1'b0};
  endfunction

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa, sb, sh;
    longint      sp;
    longint unsigned up;
    logic        ovf;
    sa  = a;
    sb  = b;
    sh  = int'(b % 32);
    sp  = longint'(sa) * longint'(sb);
    up  = 64'(a) * 64'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << sh;
      9:  return a >> sh;
      10: return 32'(sa >>> sh);
      11: return b;
      12: return sp[31:0];
      13: return sp[63:32];
      14: return up[63:32];
      15: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      16: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      17: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, wait for it to reach MEM, optionally stall MEM, then let it leave.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int stall);
    int          cyc, lat;
    logic        done;
    logic [31:0] pc;
    logic [4:0]  wa;
    pc  = $urandom;
    wa  = 5'($urandom);
    lat = (op >= 15) ? 34 : 1;
    @(negedge clk);
    check("allowin_idle", 64'(bus.exe_allowin), 64'd1);
    bus.id_to_exe_valid = 1'b1;
    bus.id_to_exe_zip   = make_zip(op, 1'b0, a, b, 4'd0, 1'b1, wa, 32'd0, pc, 1'b0);
    bus.mem_allowin     = 1'b1;
    @(posedge clk);
    #1;
    bus.id_to_exe_valid = 1'b0;
    bus.mem_allowin     = (stall == 0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.exe_to_mem_valid) begin
        done = 1'b1;
      end else begin
        check("not_ready", 64'(bus.exe_rf_zip[38]), 64'd1);
        check("allowin_busy", 64'(bus.exe_allowin), 64'd0);
      end
    end
    check("timeout", 64'(done), 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    check("result", 64'(bus.exe_to_mem_zip[79:48]), 64'(exp));
    check("pc", 64'(bus.exe_to_mem_zip[47:16]), 64'(pc));
    check("fwd", 64'(bus.exe_rf_zip), 64'({1'b0, 1'b1, wa, exp}));
    for (int s = 0; s < stall; s++) begin
      check("stall_allowin", 64'(bus.exe_allowin), 64'd0);
      @(negedge clk);
      check("stall_hold", 64'({bus.exe_to_mem_valid, bus.exe_to_mem_zip[79:48]}),
            64'({1'b1, exp}));
    end
    bus.mem_allowin = 1'b1;
    #1;
    check("fire_allowin", 64'(bus.exe_allowin), 64'd1);
  endtask

  // Issue an add-addressed load/store and check the SRAM request in its single EXE cycle.
  task automatic run_mem(input logic rfm, input logic [3:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rkd, input logic wbex,
                         input logic exv);
    logic [31:0] addr, exp_wdata;
    logic [3:0]  exp_we;
    logic        store, exp_en;
    addr   = a + b;
    store  = mop[2];
    exp_en = (rfm | store) & ~wbex & ~exv;
    case (mop[1:0])
      2'b00:   begin exp_we = 4'(1 << (addr % 4)); exp_wdata = (rkd & 32'hFF) * 32'h0101_0101; end
      2'b01:   begin exp_we = 4'(3 << (addr & 2)); exp_wdata = (rkd & 32'hFFFF) * 32'h0001_0001; end
      default: begin exp_we = 4'hF; exp_wdata = rkd; end
    endcase
    if (!store) exp_we = 4'h0;
    @(negedge clk);
    check("mem_allowin_idle", 64'(bus.exe_allowin), 64'd1);
    bus.id_to_exe_valid = 1'b1;
    bus.id_to_exe_zip   = make_zip(0, rfm, a, b, mop, rfm, 5'd3, rkd, 32'h1c00_0000, exv);
    bus.mem_allowin     = 1'b1;
    @(posedge clk);
    #1;
    bus.id_to_exe_valid = 1'b0;
    mem_wb_ex           = wbex;
    @(negedge clk);
    check("sram_en", 64'(bus.data_sram_en), 64'(exp_en));
    check("sram_addr", 64'(bus.data_sram_addr), 64'(addr));
    check("mem_fwd_nr", 64'(bus.exe_rf_zip[38]), 64'(rfm));
    check("mem_exv_pass", 64'(bus.exe_to_mem_zip[15]), 64'(exv));
    if (exp_en) begin
      check("sram_we", 64'(bus.data_sram_we), 64'(exp_we));
      if (store) check("sram_wdata", 64'(bus.data_sram_wdata), 64'(exp_wdata));
    end
    mem_wb_ex = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    int          op;
    resetn              = 1'b0;
    flush               = 1'b0;
    mem_wb_ex           = 1'b0;
    bus.id_to_exe_valid = 1'b0;
    bus.id_to_exe_zip   = '0;
    bus.mem_allowin     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_allowin", 64'(bus.exe_allowin), 64'd1);
    check("rst_valid", 64'(bus.exe_to_mem_valid), 64'd0);
    check("rst_sram_en", 64'(bus.data_sram_en), 64'd0);
    check("rst_rf_zip", 64'(bus.exe_rf_zip), 64'd0);
    check("rst_mem_zip", 64'(bus.exe_to_mem_zip[63:0]), 64'd0);
    resetn = 1'b1;

    run_op(0, 32'd5, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(13, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(14, 32'h8000_0000, 32'd2, 32'h0000_0001, 0);
    run_op(12, 32'h8000_0000, 32'd2, 32'h0000_0000, 1);
    run_op(15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op(16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 2);
    run_op(17, 32'd10, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(18, 32'd10, 32'd0, 32'd10, 0);
    run_op(15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(10, 32'h8000_00F0, 32'd36, 32'hF800_000F, 0);

    run_mem(1'b0, 4'b0100, 32'h1000, 32'd3, 32'h1234_5678, 1'b0, 1'b0);
    run_mem(1'b0, 4'b0100, 32'h1000, 32'd3, 32'h1234_5678, 1'b1, 1'b0);

    // Flush a divide mid-iteration (EXE cycle 12 = BUSY step 10).
    @(negedge clk);
    bus.id_to_exe_valid = 1'b1;
    bus.id_to_exe_zip   = make_zip(15, 1'b0, 32'd100, 32'd7, 4'd0, 1'b1, 5'd1, 32'd0,
                                   32'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.id_to_exe_valid = 1'b0;
    repeat (12) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_allowin", 64'(bus.exe_allowin), 64'd1);
    check("flush_valid", 64'(bus.exe_to_mem_valid), 64'd0);
    check("flush_nr", 64'(bus.exe_rf_zip[38]), 64'd0);
    run_op(0, 32'd40, 32'd2, 32'd42, 0);
    run_op(15, 32'd100, 32'd7, 32'd14, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 18);
      a  = rnd_val();
      b  = rnd_val();
      run_op(op, a, b, ref_result(op, a, b), $urandom_range(0, 2));
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0] mop;
      logic       rfm;
      rfm = 1'($urandom_range(0, 1));
      mop = {1'b0, ~rfm, 2'($urandom_range(0, 2))};
      run_mem(rfm, mop, $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
